// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: RV32I control path. Decodes the opcode in ID and carries the
// control bundle through ID/EX, EX/MEM and MEM/WB with per-stage valid bits.
// Load-use stall, EX flush and an external hold are resolved here.
module ctrl_pipeline #(
  parameter int REG_W    = 5,
  parameter int ALU_OP_W = 2,
  parameter int UPPER_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [6:0]          id_opcode,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                flush_ex,
  input  logic                hold,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                load_use_stall,
  output logic                ex_valid,
  output logic                ex_alu_src,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                ex_upper,
  output logic                ex_illegal,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [REG_W-1:0]    ex_rd,
  output logic                mem_valid,
  output logic                mem_read,
  output logic                mem_write,
  output logic [REG_W-1:0]    mem_rd,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic [REG_W-1:0]    wb_rd
);

  // valid shift register: [0]=EX, [1]=MEM, [2]=WB
  localparam int STAGES = 2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                branch;
    logic                jump;
    logic                upper;
    logic                illegal;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                reg_write;
  } ctrl_t;

  typedef struct packed {
    ctrl_t            c;
    logic [REG_W-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] rd;
  } wb_t;

  ctrl_t             dec;
  logic              uses_rs1, uses_rs2;
  logic              ex_load;
  ex_t               ex_next;
  ex_t               ex_q;
  mem_t              mem_q;
  wb_t               wb_q;
  logic [STAGES:0]   vld_pipe;

  // ID decode; unknown opcodes (and upper ops when disabled) flag illegal only
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec.alu_op    = ALU_OP_W'(2'b10);
        dec.reg_write = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_IALU: begin
        dec.alu_op    = ALU_OP_W'(2'b11);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        dec.alu_op = ALU_OP_W'(2'b01);
        dec.branch = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        uses_rs1      = 1'b0;
      end
      OP_JALR: begin
        dec.alu_src   = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        uses_rs1 = 1'b0;
        if (UPPER_EN != 0) begin
          dec.upper     = 1'b1;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // writes to x0 are architecturally dropped
    if (id_rd == '0) dec.reg_write = 1'b0;
  end

  // load in EX feeding a source of the instruction in ID
  assign load_use_stall = vld_pipe[0] & ex_q.c.mem_read & (ex_q.rd != '0) & id_valid &
                          ((uses_rs1 & (ex_q.rd == id_rs1)) |
                           (uses_rs2 & (ex_q.rd == id_rs2)));

  // fetch advances on flush (target load) even if a stall is also present
  assign pc_write   = ~hold & (flush_ex | ~load_use_stall);
  assign ifid_write = pc_write;

  // ID/EX input: decoded bundle, or a bubble on flush/stall/empty ID
  always_comb begin
    ex_load = id_valid & ~flush_ex & ~load_use_stall;
    ex_next = '0;
    if (ex_load) begin
      ex_next.c  = dec;
      ex_next.rd = id_rd;
    end
  end

  // stage registers; hold freezes everything, reset clears to bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
    end else if (!hold) begin
      vld_pipe         <= {vld_pipe[STAGES-1:0], ex_load};
      ex_q             <= ex_next;
      mem_q.mem_read   <= ex_q.c.mem_read;
      mem_q.mem_write  <= ex_q.c.mem_write;
      mem_q.mem_to_reg <= ex_q.c.mem_to_reg;
      mem_q.reg_write  <= ex_q.c.reg_write;
      mem_q.rd         <= ex_q.rd;
      wb_q.mem_to_reg  <= mem_q.mem_to_reg;
      wb_q.reg_write   <= mem_q.reg_write;
      wb_q.rd          <= mem_q.rd;
    end
  end

  assign ex_valid      = vld_pipe[0];
  assign ex_alu_src    = ex_q.c.alu_src;
  assign ex_branch     = ex_q.c.branch;
  assign ex_jump       = ex_q.c.jump;
  assign ex_upper      = ex_q.c.upper;
  assign ex_illegal    = ex_q.c.illegal;
  assign ex_alu_op     = ex_q.c.alu_op;
  assign ex_rd         = ex_q.rd;

  assign mem_valid     = vld_pipe[1];
  assign mem_read      = mem_q.mem_read & vld_pipe[1];
  assign mem_write     = mem_q.mem_write & vld_pipe[1];
  assign mem_rd        = mem_q.rd;

  assign wb_valid      = vld_pipe[2];
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed steps with a due-cycle scoreboard. Two DUTs share
// stimulus: u1 with UPPER_EN=1, u0 with UPPER_EN=0.
module tb_ctrl_pipeline;
  localparam int RW = 5;
  localparam int AW = 2;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_BAD = 7'b1111111;

  // scoreboard selectors
  localparam int S_EXC = 0, S_EXRD = 1, S_MEMC = 2, S_MEMRD = 3, S_WBC = 4, S_WBRD = 5,
                 S_EXC0 = 6, S_WBC0 = 7;

  logic clk = 1'b0;
  logic rst, id_valid, flush_ex, hold;
  logic [6:0] id_opcode;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;

  logic pc_write, ifid_write, load_use_stall;
  logic ex_valid, ex_alu_src, ex_branch, ex_jump, ex_upper, ex_illegal;
  logic [AW-1:0] ex_alu_op;
  logic [RW-1:0] ex_rd, mem_rd, wb_rd;
  logic mem_valid, mem_read, mem_write, wb_valid, wb_reg_write, wb_mem_to_reg;

  logic z_pc_write, z_ifid_write, z_load_use_stall;
  logic z_ex_valid, z_ex_alu_src, z_ex_branch, z_ex_jump, z_ex_upper, z_ex_illegal;
  logic [AW-1:0] z_ex_alu_op;
  logic [RW-1:0] z_ex_rd, z_mem_rd, z_wb_rd;
  logic z_mem_valid, z_mem_read, z_mem_write, z_wb_valid, z_wb_reg_write, z_wb_mem_to_reg;

  ctrl_pipeline #(.REG_W(RW), .ALU_OP_W(AW), .UPPER_EN(1)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush_ex(flush_ex), .hold(hold),
    .pc_write(pc_write), .ifid_write(ifid_write), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_upper(ex_upper), .ex_illegal(ex_illegal), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd));

  ctrl_pipeline #(.REG_W(RW), .ALU_OP_W(AW), .UPPER_EN(0)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush_ex(flush_ex), .hold(hold),
    .pc_write(z_pc_write), .ifid_write(z_ifid_write), .load_use_stall(z_load_use_stall),
    .ex_valid(z_ex_valid), .ex_alu_src(z_ex_alu_src), .ex_branch(z_ex_branch),
    .ex_jump(z_ex_jump), .ex_upper(z_ex_upper), .ex_illegal(z_ex_illegal),
    .ex_alu_op(z_ex_alu_op), .ex_rd(z_ex_rd), .mem_valid(z_mem_valid),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .mem_rd(z_mem_rd),
    .wb_valid(z_wb_valid), .wb_reg_write(z_wb_reg_write), .wb_mem_to_reg(z_wb_mem_to_reg),
    .wb_rd(z_wb_rd));

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // cycle index: bumps on every active edge
  always @(posedge clk) cyc <= cyc + 1;

  // packed snapshots: EX {valid,alu_src,branch,jump,upper,illegal,alu_op},
  // MEM {valid,read,write}, WB {valid,reg_write,mem_to_reg}
  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_EXC:   return {24'b0, ex_valid, ex_alu_src, ex_branch, ex_jump, ex_upper, ex_illegal, ex_alu_op};
      S_EXRD:  return {27'b0, ex_rd};
      S_MEMC:  return {29'b0, mem_valid, mem_read, mem_write};
      S_MEMRD: return {27'b0, mem_rd};
      S_WBC:   return {29'b0, wb_valid, wb_reg_write, wb_mem_to_reg};
      S_WBRD:  return {27'b0, wb_rd};
      S_EXC0:  return {24'b0, z_ex_valid, z_ex_alu_src, z_ex_branch, z_ex_jump, z_ex_upper,
                       z_ex_illegal, z_ex_alu_op};
      S_WBC0:  return {29'b0, z_wb_valid, z_wb_reg_write, z_wb_mem_to_reg};
      default: return 32'hdead_beef;
    endcase
  endfunction

  // scoreboard compare: every entry due this cycle, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [31:0] obs;
        obs = sample(sb[i].sel);
        vectors++;
        assert (obs === sb[i].val) else begin
          miscompares++;
          $error("FAIL %s @cyc %0d: observed %0h expected %0h", sb[i].tag, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int due, input int sel, input logic [31:0] val, input string tag);
    exp_t e;
    e.due = due; e.sel = sel; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] opc, input int rs1, input int rs2, input int rd);
    id_valid  = 1'b1;
    id_opcode = opc;
    id_rs1    = RW'(rs1);
    id_rs2    = RW'(rs2);
    id_rd     = RW'(rd);
    #1;
  endtask

  task automatic idle();
    id_valid  = 1'b0;
    id_opcode = '0;
    id_rs1    = '0;
    id_rs2    = '0;
    id_rd     = '0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rst = 1'b1; flush_ex = 1'b0; hold = 1'b0;
    idle();
    tick();
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_ifid_write", 32'(ifid_write), 32'd1);
    chk("rst_stall", 32'(load_use_stall), 32'd0);
    chk("rst_ex", sample(S_EXC), 32'h0);
    chk("rst_wb", sample(S_WBC), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // straight line: ADD x3, SW, BEQ
    t0 = cyc;
    issue(OP_R, 1, 2, 3);
    chk("sl_pc_write", 32'(pc_write), 32'd1);
    push(t0+1, S_EXC, 32'h82, "add_ex");  push(t0+1, S_EXRD, 32'd3, "add_exrd");
    push(t0+2, S_MEMC, 32'h4, "add_mem"); push(t0+2, S_MEMRD, 32'd3, "add_memrd");
    push(t0+3, S_WBC, 32'h6, "add_wb");   push(t0+3, S_WBRD, 32'd3, "add_wbrd");
    tick();
    issue(OP_ST, 1, 3, 0);
    chk("sl_no_stall", 32'(load_use_stall), 32'd0);
    push(t0+2, S_EXC, 32'hC0, "sw_ex"); push(t0+3, S_MEMC, 32'h5, "sw_mem");
    push(t0+4, S_WBC, 32'h4, "sw_wb");
    tick();
    issue(OP_BR, 3, 4, 0);
    push(t0+3, S_EXC, 32'hA1, "beq_ex"); push(t0+4, S_MEMC, 32'h4, "beq_mem");
    push(t0+5, S_WBC, 32'h4, "beq_wb");
    tick();
    idle();
    push(t0+4, S_EXC, 32'h0, "idle_ex");
    drain("sl_drain");

    // load-use: LW x5 then ADD x6,x5,x1
    t0 = cyc;
    issue(OP_LD, 1, 0, 5);
    push(t0+1, S_EXC, 32'hC0, "lw_ex");  push(t0+1, S_EXRD, 32'd5, "lw_exrd");
    push(t0+2, S_MEMC, 32'h6, "lw_mem"); push(t0+3, S_WBC, 32'h7, "lw_wb");
    push(t0+3, S_WBRD, 32'd5, "lw_wbrd");
    tick();
    issue(OP_R, 5, 1, 6);
    chk("lu_stall", 32'(load_use_stall), 32'd1);
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_ifid_write", 32'(ifid_write), 32'd0);
    push(t0+2, S_EXC, 32'h0, "lu_bubble");
    tick();
    chk("lu_clear", 32'(load_use_stall), 32'd0);
    chk("lu_pc_resume", 32'(pc_write), 32'd1);
    push(t0+3, S_EXC, 32'h82, "lu_add_ex"); push(t0+3, S_EXRD, 32'd6, "lu_add_exrd");
    push(t0+4, S_WBC, 32'h0, "lu_bubble_wb"); push(t0+5, S_WBC, 32'h6, "lu_add_wb");
    tick();
    idle();
    drain("lu_drain");

    // independent ADD after LW: no stall
    t0 = cyc;
    issue(OP_LD, 1, 0, 5);
    tick();
    issue(OP_R, 1, 2, 6);
    chk("nodep_stall", 32'(load_use_stall), 32'd0);
    push(t0+2, S_EXC, 32'h82, "nodep_ex");
    tick();
    // ADDI with rs2 field matching the load: rs2 unused, no stall
    idle();
    tick();
    t0 = cyc;
    issue(OP_LD, 1, 0, 5);
    tick();
    issue(OP_I, 1, 5, 6);
    chk("addi_rs2_stall", 32'(load_use_stall), 32'd0);
    push(t0+2, S_EXC, 32'hC3, "addi_ex");
    tick();
    // store data from the load: rs2 used, stall
    issue(OP_LD, 1, 0, 5);
    tick();
    issue(OP_ST, 1, 5, 0);
    chk("sw_rs2_stall", 32'(load_use_stall), 32'd1);
    tick();
    chk("sw_rs2_clear", 32'(load_use_stall), 32'd0);
    tick();
    idle();
    drain("rs_drain");

    // LW x0: never a hazard, reg_write dropped
    t0 = cyc;
    issue(OP_LD, 1, 0, 0);
    push(t0+1, S_EXC, 32'hC0, "lw0_ex"); push(t0+1, S_EXRD, 32'd0, "lw0_exrd");
    push(t0+3, S_WBC, 32'h5, "lw0_wb");
    tick();
    issue(OP_R, 0, 1, 6);
    chk("lw0_stall", 32'(load_use_stall), 32'd0);
    push(t0+2, S_EXC, 32'h82, "lw0_add_ex");
    tick();
    idle();
    drain("lw0_drain");

    // flush with a pending load-use: flush wins
    t0 = cyc;
    issue(OP_LD, 1, 0, 5);
    push(t0+1, S_EXC, 32'hC0, "fl_lw_ex");
    tick();
    issue(OP_R, 5, 1, 6);
    flush_ex = 1'b1;
    #1;
    chk("fl_pc_write", 32'(pc_write), 32'd1);
    chk("fl_ifid_write", 32'(ifid_write), 32'd1);
    push(t0+2, S_EXC, 32'h0, "fl_bubble"); push(t0+2, S_MEMC, 32'h6, "fl_lw_mem");
    tick();
    flush_ex = 1'b0;
    idle();
    drain("fl_drain");

    // hold for 3 cycles mid-stream, flush offered during hold is ignored
    t0 = cyc;
    issue(OP_R, 1, 2, 3);
    push(t0+1, S_EXC, 32'h82, "h_add_ex");
    tick();
    issue(OP_ST, 1, 3, 0);
    push(t0+2, S_EXC, 32'hC0, "h_sw_ex");
    tick();
    issue(OP_BR, 3, 4, 0);
    hold = 1'b1;
    #1;
    chk("h_pc_write", 32'(pc_write), 32'd0);
    chk("h_ifid_write", 32'(ifid_write), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      push(t0+k, S_EXC, 32'hC0, "h_frz_ex");
      push(t0+k, S_MEMC, 32'h4, "h_frz_mem");
      push(t0+k, S_MEMRD, 32'd3, "h_frz_memrd");
      push(t0+k, S_WBC, 32'h0, "h_frz_wb");
    end
    tick();
    flush_ex = 1'b1;
    #1;
    chk("h_flush_pc_write", 32'(pc_write), 32'd0);
    tick();
    flush_ex = 1'b0;
    tick();
    hold = 1'b0;
    #1;
    chk("h_release_pc", 32'(pc_write), 32'd1);
    push(t0+6, S_EXC, 32'hA1, "h_beq_ex"); push(t0+6, S_MEMC, 32'h5, "h_sw_mem");
    push(t0+6, S_WBC, 32'h6, "h_add_wb");  push(t0+6, S_WBRD, 32'd3, "h_add_wbrd");
    push(t0+7, S_MEMC, 32'h4, "h_beq_mem"); push(t0+7, S_WBC, 32'h4, "h_sw_wb");
    push(t0+8, S_WBC, 32'h4, "h_beq_wb");
    tick();
    idle();
    drain("h_drain");

    // asynchronous reset mid-stream with an ADD writing back
    issue(OP_R, 1, 2, 3);
    tick();
    idle();
    tick();
    tick();
    chk("pre_rst_wb", sample(S_WBC), 32'h6);
    rst = 1'b1;
    #1;
    chk("mid_rst_ex", sample(S_EXC), 32'h0);
    chk("mid_rst_mem", sample(S_MEMC), 32'h0);
    chk("mid_rst_wb", sample(S_WBC), 32'h0);
    chk("mid_rst_wbrd", sample(S_WBRD), 32'h0);
    chk("mid_rst_pc", 32'(pc_write), 32'd1);
    tick();
    rst = 1'b0;
    t0 = cyc;
    issue(OP_R, 1, 2, 3);
    push(t0+1, S_EXC, 32'h82, "post_rst_ex");
    tick();
    idle();
    drain("rst_drain");

    // upper / illegal / jumps, UPPER_EN=1 (u1) vs UPPER_EN=0 (u0)
    t0 = cyc;
    issue(OP_LUI, 3, 0, 7);
    push(t0+1, S_EXC, 32'hC8, "lui_ex"); push(t0+1, S_EXC0, 32'h84, "lui_ex_noup");
    push(t0+3, S_WBC, 32'h6, "lui_wb");  push(t0+3, S_WBC0, 32'h4, "lui_wb_noup");
    tick();
    issue(OP_BAD, 0, 0, 7);
    push(t0+2, S_EXC, 32'h84, "bad_ex"); push(t0+2, S_EXC0, 32'h84, "bad_ex_noup");
    push(t0+4, S_WBC, 32'h4, "bad_wb");
    tick();
    issue(OP_JAL, 0, 0, 1);
    push(t0+3, S_EXC, 32'h90, "jal_ex"); push(t0+5, S_WBC, 32'h6, "jal_wb");
    tick();
    issue(OP_JALR, 2, 0, 1);
    push(t0+4, S_EXC, 32'hD0, "jalr_ex");
    tick();
    issue(OP_AUIPC, 0, 0, 2);
    push(t0+5, S_EXC, 32'hC8, "auipc_ex"); push(t0+5, S_EXC0, 32'h84, "auipc_ex_noup");
    tick();
    issue(OP_I, 1, 0, 0);
    push(t0+6, S_EXC, 32'hC3, "addi_x0_ex"); push(t0+8, S_WBC, 32'h4, "addi_x0_wb");
    tick();
    issue(OP_R, 1, 2, 3);
    id_valid = 1'b0;
    push(t0+7, S_EXC, 32'h0, "novalid_ex"); push(t0+7, S_EXRD, 32'd0, "novalid_exrd");
    tick();
    idle();
    drain("dec_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Parametrised pipelined control path for the 5-stage RV32I core. It decodes the instruction's opcode in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers with valid bits. Load-use hazard detection, branch flush and an external hold are handled internally. The outputs drive the EX, MEM and WB stages directly, plus `pc_write` and `ifid_write` toward fetch.

## Interface
- `REG_W`, 5: register-index width.
- `ALU_OP_W`, 2: width of the ALU-op class field.
- `UPPER_EN`, 1: when 1, decode LUI (0110111) and AUIPC (0010111); when 0, they are illegal.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: the IF/ID register holds a real instruction.
- `id_opcode` in 7: the instruction's opcode field in ID.
- `id_rs1`, `id_rs2`, `id_rd` in REG_W: register indices in ID.
- `flush_ex` in 1: a branch or jump taken was resolved in EX this cycle.
- `hold` in 1: external memory wait; freezes the whole pipeline.
- `pc_write`, `ifid_write` out 1: update enables for PC and IF/ID.
- `load_use_stall` out 1: hazard indication (combinational).
- `ex_valid`, `ex_alu_src`, `ex_branch`, `ex_jump`, `ex_upper`, `ex_illegal` out 1: EX-stage control.
- `ex_alu_op` out ALU_OP_W: EX-stage ALU-op class.
- `ex_rd` out REG_W: destination index in EX.
- `mem_valid`, `mem_read`, `mem_write` out 1: MEM-stage control.
- `mem_rd` out REG_W: destination index in MEM.
- `wb_valid`, `wb_reg_write`, `wb_mem_to_reg` out 1: WB-stage control.
- `wb_rd` out REG_W: destination index in WB.

## Operation
**Decode (combinational, ID stage)**
- R (0110011): alu_op=10, reg_write.
- I-ALU (0010011): alu_op=11, alu_src, reg_write.
- Load (0000011): alu_op=00, alu_src, mem_read, mem_to_reg, reg_write.
- Store (0100011): alu_op=00, alu_src, mem_write.
- Branch (1100011): alu_op=01, branch.
- JAL (1101111): jump, reg_write.
- JALR (1100111): alu_op=00, alu_src, jump, reg_write.
- LUI/AUIPC (when UPPER_EN): upper, alu_src, reg_write.
- Any other opcode: all controls 0, illegal=1.
- No X values are ever produced; all don't-cares decode to 0.
- reg_write is forced to 0 when rd==0.
- rs2 is used only by R, Store and Branch.

**Hazard**
- `load_use_stall` = ex_valid & mem_read-in-EX & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | (uses_rs2 & ex_rd==id_rs2)).
- rs1 is ignored for JAL, LUI and AUIPC.

**Stage update per cycle, in priority order**
1. `rst`: all stage registers are cleared to bubble.
2. `hold`: all stage registers keep their values; pc_write=0, ifid_write=0.
3. `flush_ex`: ID/EX loads a bubble; EX/MEM and MEM/WB advance; pc_write=1, ifid_write=1. Fetch loads the target; the IF/ID kill is handled by the fetch block. Flush overrides load_use_stall.
4. `load_use_stall`: ID/EX loads a bubble; EX/MEM and MEM/WB advance; pc_write=0, ifid_write=0.
5. Otherwise: all stages advance; ID/EX loads the decode result with valid=id_valid; pc_write=1, ifid_write=1.

**Rules**
- Bubble = every control 0, valid 0, rd 0.
- id_valid=0 loads a bubble.
- Stage outputs are the registered values.
- mem_read and mem_write are additionally gated by mem_valid.

## Timing
- Reset values: every output register is 0. pc_write=1 and ifid_write=1 during and after reset unless hold=1. load_use_stall=0.
- Latency: decode visible at EX outputs 1 cycle after ID capture, MEM after 2, WB after 3.
- A load-use stall lasts exactly 1 cycle; after the bubble, the load is in MEM and the condition clears.
- Flush and stall in the same cycle: flush wins; pc_write=1.
- hold together with flush_ex or stall: hold wins, and the flush must be re-presented by EX because the EX contents are frozen.
- Asserting `rst` mid-operation clears all stages within the same cycle (asynchronous). Normal operation resumes on the first edge after deassertion.

## Test plan
- **Reset:** assert rst mid-stream with wb_reg_write=1 -> all stage outputs 0 immediately; pc_write=1.
- **Straight line:** ADD x3 (rd=3), then SW, then BEQ at 1/cycle -> ex/mem/wb fields appear at +1/+2/+3 cycles; wb_reg_write=1 only for ADD.
- **Load-use:** LW x5, then ADD x6,x5,x1 -> load_use_stall=1 for 1 cycle, pc_write=0, ex_valid=0 bubble, ADD enters EX one cycle later. Repeat with ADD x6,x1,x2 -> no stall. Repeat with LW x0 -> no stall.
- **Flush:** flush_ex=1 while LW x5 is in EX and a dependent ADD is in ID -> ADD bubbled, no stall, pc_write=1, LW reaches mem_read=1 next cycle.
- **Hold:** hold=1 for 3 cycles mid-stream -> all outputs constant, pc_write=0; the sequence resumes unchanged after release.
- **Illegal/upper:** opcode 0110111 with UPPER_EN=1 -> ex_upper=1, reg_write=1. With UPPER_EN=0 -> ex_illegal=1, all other controls 0. Opcode 1111111 -> ex_illegal=1.
